// File: rtl/xbar_route4_pkg.sv
// Shared constants, lane state encodings and the round-robin pick helper
// for the 4x4 ingress-to-egress routing stage.
package xbar_route4_pkg;

    localparam int NLANE     = 4;
    localparam int XB_DATA_W = 10;
    localparam int DEST_HI   = XB_DATA_W - 1;
    localparam int DEST_LO   = XB_DATA_W - 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    typedef logic [1:0] lane_idx_t;

    typedef struct packed {
        logic      vld;
        lane_idx_t idx;
    } pick_t;

    // Scan offsets from the far end back towards ptr so the nearest requester wins.
    function automatic pick_t rr_pick(input logic [NLANE-1:0] req, input lane_idx_t ptr);
        pick_t     p;
        lane_idx_t c;
        p = '0;
        for (int k = NLANE - 1; k >= 0; k--) begin
            c = ptr + lane_idx_t'(k);
            if (req[c]) begin
                p.vld = 1'b1;
                p.idx = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/xbar_route4_if.sv
// FIFO-side bundle of the routing stage: ingress read port and egress write port.
// master = the router, slave = the FIFO bank.
interface xbar_route4_if
    import xbar_route4_pkg::*;
#(
    parameter int DATA_W = XB_DATA_W
);
    logic [NLANE*DATA_W-1:0] in_data;
    logic [NLANE-1:0]        in_empty;
    logic [NLANE-1:0]        in_pop;
    logic [NLANE*DATA_W-1:0] out_data;
    logic [NLANE-1:0]        out_push;
    logic [NLANE-1:0]        out_afull;

    modport master (
        input  in_data, in_empty, out_afull,
        output in_pop, out_data, out_push
    );

    modport slave (
        output in_data, in_empty, out_afull,
        input  in_pop, out_data, out_push
    );
endinterface

// File: rtl/xbar_route4_rr_arb4.sv
// Per-egress round-robin arbiter over four lanes; the pointer only moves on a
// grant, landing one past the winner.
module rr_arb4
    import xbar_route4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NLANE-1:0] i_req,
    input  logic             i_afull,
    output logic [NLANE-1:0] o_gnt,
    output lane_idx_t        o_idx,
    output logic             o_vld
);
    lane_idx_t r_ptr;
    pick_t     w_pick;

    assign w_pick = rr_pick(i_req, r_ptr);
    assign o_vld  = w_pick.vld & ~i_afull;
    assign o_idx  = w_pick.idx;
    assign o_gnt  = o_vld ? (NLANE'(1) << w_pick.idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_vld) begin
            r_ptr <= w_pick.idx + 2'd1;
        end
    end
endmodule

// File: rtl/xbar_route4.sv
// 4x4 routing stage: each lane pops one word, holds it until its destination
// egress grants it, then pushes it through a registered output stage.
module xbar_route4
    import xbar_route4_pkg::*;
#(
    parameter int DATA_W = XB_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    xbar_route4_if.master bus
);
    logic [NLANE-1:0][DATA_W-1:0] w_in;
    logic [NLANE-1:0][DATA_W-1:0] w_hold;
    logic [NLANE-1:0][NLANE-1:0]  w_req;      // [egress][lane]
    logic [NLANE-1:0][NLANE-1:0]  w_gnt;      // [egress][lane]
    logic [NLANE-1:0][NLANE-1:0]  w_gnt_by_lane;  // [lane][egress]
    lane_idx_t [NLANE-1:0]        w_gidx;
    logic [NLANE-1:0]             w_gvld;

    assign w_in = bus.in_data;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        logic [1:0]        r_state;
        logic [DATA_W-1:0] r_hold;
        logic [1:0]        w_dest;
        logic              w_lane_gnt;
        logic              w_pop;

        assign w_dest     = r_hold[DATA_W-1 -: 2];
        assign w_lane_gnt = |w_gnt_by_lane[i];
        assign w_hold[i]  = r_hold;

        // A lane pops only when it has nothing outstanding: idle, or leaving HELD on a grant.
        assign w_pop = ~reset & ~bus.in_empty[i] &
                       ((r_state == ST_IDLE) | ((r_state == ST_HELD) & w_lane_gnt));
        assign bus.in_pop[i] = w_pop;

        for (genvar j = 0; j < NLANE; j++) begin : g_req
            assign w_req[j][i]         = (r_state == ST_HELD) & (w_dest == 2'(j));
            assign w_gnt_by_lane[i][j] = w_gnt[j][i];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_hold  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_pop) r_state <= ST_WAIT;
                    ST_WAIT: begin
                        r_hold  <= w_in[i];
                        r_state <= ST_HELD;
                    end
                    ST_HELD: if (w_lane_gnt) r_state <= w_pop ? ST_WAIT : ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar j = 0; j < NLANE; j++) begin : g_egr
        logic              r_push;
        logic [DATA_W-1:0] r_data;

        rr_arb4 u_arb (
            .clk     (clk),
            .reset   (reset),
            .i_req   (w_req[j]),
            .i_afull (bus.out_afull[j]),
            .o_gnt   (w_gnt[j]),
            .o_idx   (w_gidx[j]),
            .o_vld   (w_gvld[j])
        );

        // Data is left untouched on idle cycles so the egress bus stays quiet.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_push <= 1'b0;
                r_data <= '0;
            end else begin
                r_push <= w_gvld[j];
                if (w_gvld[j]) r_data <= w_hold[w_gidx[j]];
            end
        end

        assign bus.out_push[j]               = r_push;
        assign bus.out_data[j*DATA_W +: DATA_W] = r_data;
    end
endmodule
